// File: rtl/csr_wdt_timer_pkg.sv
// Shared register map, field positions and defaults for the CSR watchdog timer.
package csr_wdt_timer_pkg;

  localparam logic [9:0] REG_CTRL    = 10'd0;
  localparam logic [9:0] REG_COMPARE = 10'd1;
  localparam logic [9:0] REG_COUNTER = 10'd2;
  localparam logic [9:0] REG_STATUS  = 10'd3;
  localparam logic [9:0] REG_KICK    = 10'd4;

  localparam int unsigned CTRL_EN           = 0;
  localparam int unsigned CTRL_AUTORELOAD   = 1;
  localparam int unsigned CTRL_IRQ_EN       = 2;
  localparam int unsigned CTRL_WDT_EN       = 3;
  localparam int unsigned CTRL_PRESCALE_LSB = 8;

  localparam int unsigned STATUS_MATCH     = 0;
  localparam int unsigned STATUS_WDT_FIRED = 1;

  localparam logic [31:0] KICK_KEY_DEFAULT = 32'h5A5A_5A5A;

  typedef struct packed {
    logic [7:0] prescale;
    logic       wdt_en;
    logic       irq_en;
    logic       autoreload;
    logic       en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_to_word(ctrl_t c);
    return {16'h0000, c.prescale, 4'h0, c.wdt_en, c.irq_en, c.autoreload, c.en};
  endfunction

endpackage

// File: rtl/csr_wdt_timer_prescaler.sv
// 8-bit prescaler: ticks when the count equals the prescale value, then restarts from 0.
module csr_wdt_timer_prescaler (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [7:0] prescale_i,
  output logic       tick_o
);

  logic [7:0] cnt_q, cnt_d;
  logic       hit;

  assign hit    = (cnt_q == prescale_i);
  assign tick_o = en_i & hit;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'h00;
    end else if (en_i) begin
      cnt_d = hit ? 8'h00 : cnt_q + 8'h01;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/csr_wdt_timer.sv
// CSR-mapped prescaled compare timer with interrupt and sticky watchdog reset pulse.
module csr_wdt_timer
  import csr_wdt_timer_pkg::*;
#(
  parameter logic [3:0]  csr_addr  = 4'h0,
  parameter int unsigned RST_PULSE = 16,
  parameter logic [31:0] KICK_KEY  = KICK_KEY_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        irq,
  output logic        wdt_rst
);

  localparam logic [7:0] PulseLoad = 8'(RST_PULSE);

  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] counter_q, counter_d;
  logic        match_q, match_d;
  logic        fired_q, fired_d;
  logic [7:0]  pulse_q, pulse_d;
  logic        irq_q, irq_d;
  logic [31:0] do_q, do_d;

  logic        sel, wr;
  logic [9:0]  idx;
  logic        wr_ctrl, wr_compare, wr_counter, wr_status, kick;
  logic        tick_raw, tick, match_now;
  logic [31:0] rdata;

  assign sel        = (csr_a[13:10] == csr_addr);
  assign wr         = sel & csr_we;
  assign idx        = csr_a[9:0];
  assign wr_ctrl    = wr & (idx == REG_CTRL);
  assign wr_compare = wr & (idx == REG_COMPARE);
  assign wr_counter = wr & (idx == REG_COUNTER);
  assign wr_status  = wr & (idx == REG_STATUS);
  assign kick       = wr & (idx == REG_KICK) & (csr_di == KICK_KEY);

  csr_wdt_timer_prescaler u_prescaler (
    .clk_i      (sys_clk),
    .rst_ni     (sys_rst_n),
    .en_i       (ctrl_q.en),
    .clr_i      (kick),
    .prescale_i (ctrl_q.prescale),
    .tick_o     (tick_raw)
  );

  // Counter loads, kicks and an EN-clearing CTRL write all pre-empt a coincident tick.
  assign tick      = tick_raw & ~wr_counter & ~kick & ~(wr_ctrl & ~csr_di[CTRL_EN]);
  assign match_now = tick & (counter_q == compare_q);

  always_comb begin
    ctrl_d    = ctrl_q;
    compare_d = compare_q;
    counter_d = counter_q;
    match_d   = match_q;
    fired_d   = fired_q;
    pulse_d   = pulse_q;

    if (wr_ctrl) begin
      ctrl_d.en         = csr_di[CTRL_EN];
      ctrl_d.autoreload = csr_di[CTRL_AUTORELOAD];
      ctrl_d.irq_en     = csr_di[CTRL_IRQ_EN];
      ctrl_d.wdt_en     = ctrl_q.wdt_en | csr_di[CTRL_WDT_EN];
      ctrl_d.prescale   = csr_di[CTRL_PRESCALE_LSB +: 8];
    end
    if (wr_compare) begin
      compare_d = csr_di;
    end

    if (wr_counter) begin
      counter_d = csr_di;
    end else if (kick) begin
      counter_d = 32'h0;
    end else if (tick) begin
      if (match_now) begin
        if (ctrl_q.autoreload) begin
          counter_d = 32'h0;
        end else begin
          ctrl_d.en = 1'b0;
        end
      end else begin
        counter_d = counter_q + 32'h1;
      end
    end

    if (wr_status && csr_di[STATUS_MATCH]) begin
      match_d = 1'b0;
    end
    if (match_now) begin
      match_d = 1'b1;
    end

    if (match_now && ctrl_q.wdt_en) begin
      fired_d = 1'b1;
      pulse_d = PulseLoad;
    end else if (pulse_q != 8'h00) begin
      pulse_d = pulse_q - 8'h01;
    end
  end

  assign irq_d = match_d & ctrl_d.irq_en;

  always_comb begin
    rdata = 32'h0;
    case (idx)
      REG_CTRL:    rdata = ctrl_to_word(ctrl_q);
      REG_COMPARE: rdata = compare_q;
      REG_COUNTER: rdata = counter_q;
      REG_STATUS:  rdata = {30'h0, fired_q, match_q};
      default:     rdata = 32'h0;
    endcase
  end

  assign do_d = sel ? rdata : 32'h0;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ctrl_q    <= '0;
      compare_q <= 32'h0;
      counter_q <= 32'h0;
      match_q   <= 1'b0;
      fired_q   <= 1'b0;
      pulse_q   <= 8'h00;
      irq_q     <= 1'b0;
      do_q      <= 32'h0;
    end else begin
      ctrl_q    <= ctrl_d;
      compare_q <= compare_d;
      counter_q <= counter_d;
      match_q   <= match_d;
      fired_q   <= fired_d;
      pulse_q   <= pulse_d;
      irq_q     <= irq_d;
      do_q      <= do_d;
    end
  end

  assign csr_do  = do_q;
  assign irq     = irq_q;
  assign wdt_rst = (pulse_q != 8'h00);

endmodule

// File: tb/tb_csr_wdt_timer.sv
// Directed bench for csr_wdt_timer; expectations go into a scoreboard drained by a monitor.
module tb_csr_wdt_timer;

  localparam int KCsr = 0;
  localparam int KIrq = 1;
  localparam int KWdt = 2;

  localparam logic [3:0]  Pg  = 4'h0;
  localparam logic [3:0]  Oth = 4'h3;
  localparam logic [31:0] Key = 32'h5A5A_5A5A;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [13:0] csr_a = '0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_di = '0;
  logic [31:0] csr_do;
  logic        irq;
  logic        wdt_rst;

  chk_t sb[$];
  int   n_req = 0;
  int   n_vld = 0;
  int   errors = 0;
  int   checks = 0;

  csr_wdt_timer dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .csr_a     (csr_a),
    .csr_we    (csr_we),
    .csr_di    (csr_di),
    .csr_do    (csr_do),
    .irq       (irq),
    .wdt_rst   (wdt_rst)
  );

  always #5 sys_clk = ~sys_clk;

  // Expectations pushed during a cycle are due right after that cycle's edge.
  always @(posedge sys_clk) n_vld <= n_req;

  always @(negedge sys_clk) begin
    for (int i = 0; i < n_vld; i++) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
      end else begin
        chk_t        c;
        logic [31:0] act;
        c   = sb.pop_front();
        act = (c.kind == KCsr) ? csr_do : (c.kind == KIrq) ? {31'h0, irq} : {31'h0, wdt_rst};
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s: got %h, expected %h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic step(input logic rst_n, input logic we, input logic [3:0] page,
                      input logic [9:0] idx, input logic [31:0] di);
    @(negedge sys_clk);
    sys_rst_n = rst_n;
    csr_we    = we;
    csr_a     = {page, idx};
    csr_di    = di;
    n_req     = 0;
  endtask

  task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
    chk_t c;
    c.kind = kind;
    c.exp  = exp;
    c.name = name;
    sb.push_back(c);
    n_req++;
  endtask

  task automatic wr(input logic [9:0] idx, input logic [31:0] di);
    step(1'b1, 1'b1, Pg, idx, di);
  endtask

  task automatic rd(input logic [9:0] idx, input logic [31:0] exp, input string name);
    step(1'b1, 1'b0, Pg, idx, 32'h0);
    expect_val(KCsr, exp, name);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, Oth, 10'h0, 32'h0);
  endtask

  initial begin
    // 1: reset, all indices read 0, other page reads 0
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, Pg, 10'd0, 32'h0);
      expect_val(KCsr, 32'h0, "rst_csr_do");
      expect_val(KIrq, 32'h0, "rst_irq");
      expect_val(KWdt, 32'h0, "rst_wdt");
    end
    for (int i = 0; i < 6; i++) rd(10'(i), 32'h0, "rst_read_idx");
    wr(10'd1, 32'h0000_1234);
    step(1'b1, 1'b0, Oth, 10'd1, 32'h0);
    expect_val(KCsr, 32'h0, "other_page_read");
    rd(10'd1, 32'h0000_1234, "compare_readback");

    // 2: auto-reload at COMPARE=5, irq and W1C
    wr(10'd1, 32'd5);
    wr(10'd0, 32'h0000_0007);
    for (int i = 0; i < 6; i++) begin
      rd(10'd2, 32'(i), "ar_counter_seq");
      expect_val(KIrq, (i == 5) ? 32'h1 : 32'h0, "ar_irq");
    end
    rd(10'd2, 32'h0, "ar_reload_zero");
    rd(10'd3, 32'h1, "ar_status_match");
    wr(10'd0, 32'h0000_0004);
    expect_val(KIrq, 32'h1, "irq_before_clear");
    wr(10'd3, 32'h1);
    expect_val(KIrq, 32'h0, "irq_after_clear");
    rd(10'd3, 32'h0, "status_cleared");
    rd(10'd2, 32'd2, "en_clear_drops_tick");

    // 3: PRESCALE=3, COMPARE=2, one-shot
    wr(10'd2, 32'h0);
    wr(10'd1, 32'd2);
    wr(10'd0, 32'h0000_0301);
    for (int i = 0; i < 10; i++) idle();
    rd(10'd3, 32'h0, "os_status_c11");
    rd(10'd3, 32'h0, "os_status_c12");
    rd(10'd3, 32'h1, "os_status_c13");
    expect_val(KIrq, 32'h0, "os_irq_masked");
    rd(10'd0, 32'h0000_0300, "os_en_cleared");
    rd(10'd2, 32'd2, "os_counter_hold");
    idle();
    rd(10'd2, 32'd2, "os_counter_still");
    wr(10'd3, 32'h1);

    // 4: wrap through 0xFFFFFFFF
    wr(10'd2, 32'hFFFF_FFFE);
    wr(10'd1, 32'd1);
    wr(10'd0, 32'h0000_0001);
    rd(10'd2, 32'hFFFF_FFFE, "wrap_c1");
    rd(10'd2, 32'hFFFF_FFFF, "wrap_c2");
    rd(10'd2, 32'h0, "wrap_c3");
    rd(10'd2, 32'h1, "wrap_c4");
    rd(10'd3, 32'h1, "wrap_match");
    rd(10'd0, 32'h0, "wrap_en_cleared");
    wr(10'd3, 32'h1);

    // 6a: COUNTER write coincident with a tick
    wr(10'd1, 32'd100);
    wr(10'd2, 32'h0);
    wr(10'd0, 32'h0000_0003);
    wr(10'd2, 32'h0000_0050);
    rd(10'd2, 32'h0000_0050, "load_beats_tick");
    rd(10'd2, 32'h0000_0051, "load_then_count");
    wr(10'd0, 32'h0);

    // 5: watchdog serviced, then a bad kick lets it fire
    wr(10'd2, 32'h0);
    wr(10'd1, 32'd10);
    wr(10'd0, 32'h0000_000B);
    for (int k = 0; k < 4; k++) begin
      wr(10'd4, Key);
      expect_val(KWdt, 32'h0, "kick_wdt_low");
      for (int i = 0; i < 7; i++) begin
        idle();
        expect_val(KWdt, 32'h0, "kick_wdt_low");
      end
    end
    for (int i = 0; i <= 20; i++) begin
      case (i)
        0:       wr(10'd4, 32'h1234_5678);
        4:       wr(10'd0, 32'h0);
        5:       rd(10'd0, 32'h0000_0008, "wdt_en_sticky");
        6:       rd(10'd3, 32'h3, "wdt_fired_status");
        7:       rd(10'd4, 32'h0, "kick_reads_zero");
        default: idle();
      endcase
      expect_val(KWdt, (i >= 3 && i <= 18) ? 32'h1 : 32'h0, "wdt_pulse_window");
      expect_val(KIrq, 32'h0, "wdt_irq_off");
    end

    // 6b: reset truncates an active pulse
    wr(10'd3, 32'h1);
    wr(10'd1, 32'h0);
    wr(10'd0, 32'h0000_0001);
    for (int i = 0; i < 3; i++) begin
      idle();
      expect_val(KWdt, 32'h1, "refire_pulse");
    end
    step(1'b0, 1'b0, Oth, 10'h0, 32'h0);
    expect_val(KWdt, 32'h0, "rst_truncates_pulse");
    step(1'b0, 1'b0, Oth, 10'h0, 32'h0);
    rd(10'd3, 32'h0, "rst_clears_fired");
    rd(10'd0, 32'h0, "rst_clears_wdt_en");

    idle();
    idle();
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
